// File: rtl/shift_reg_universal.sv
// Universal shift register (hold / shift right / shift left / parallel load)
// with a serial bit counter that frames WIDTH-bit words and strobes word_valid.
module shift_reg_universal #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sdi_l,
  input  logic             sdi_r,
  input  logic [WIDTH-1:0] pdi,
  output logic [WIDTH-1:0] q,
  output logic             sdo_r,
  output logic             sdo_l,
  output logic [CW-1:0]    bit_cnt,
  output logic             word_valid
);

  localparam logic [1:0]    MODE_HOLD = 2'b00;
  localparam logic [1:0]    MODE_SHR  = 2'b01;
  localparam logic [1:0]    MODE_SHL  = 2'b10;
  localparam logic [1:0]    MODE_LOAD = 2'b11;
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_nxt;
  logic             shift_en;
  logic             load_en;

  // Counter advance; wraps after the last bit of a word.
  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c);
    return (c == LAST_BIT) ? '0 : c + CW'(1);
  endfunction

  always_comb begin
    q_nxt    = q;
    shift_en = 1'b0;
    load_en  = 1'b0;
    case (mode)
      MODE_SHR: begin
        q_nxt    = {sdi_l, q[WIDTH-1:1]};
        shift_en = en;
      end
      MODE_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sdi_r};
        shift_en = en;
      end
      MODE_LOAD: begin
        q_nxt   = pdi;
        load_en = en;
      end
      MODE_HOLD: q_nxt = q;
      default:   q_nxt = q;
    endcase
  end

  // State register: reset > clr > en/mode; clr freezes q and drops the partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (load_en) begin
        q       <= q_nxt;
        bit_cnt <= '0;
      end else if (shift_en) begin
        q          <= q_nxt;
        bit_cnt    <= next_cnt(bit_cnt);
        word_valid <= (bit_cnt == LAST_BIT);
      end
    end
  end

  assign sdo_r = q[0];
  assign sdo_l = q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed bench for shift_reg_universal (WIDTH=8): stimulus pushes hand-computed
// expectations into a queue; a monitor pops one entry after every clock edge.
module tb_shift_reg_universal;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sdi_l = 1'b0;
  logic       sdi_r = 1'b0;
  logic [7:0] pdi = 8'h00;
  logic [7:0] q;
  logic       sdo_r;
  logic       sdo_l;
  logic [3:0] bit_cnt;
  logic       word_valid;

  shift_reg_universal #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .mode(mode),
    .sdi_l(sdi_l), .sdi_r(sdi_r), .pdi(pdi), .q(q), .sdo_r(sdo_r),
    .sdo_l(sdo_l), .bit_cnt(bit_cnt), .word_valid(word_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       wv;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  task automatic chk(input string name, input int idx, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL step%0d %s: got %0h want %0h", idx, name, act, want);
    end
  endtask

  // Monitor: every edge the DUT presents a new state; compare it with the head of the queue.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("q",          cur.idx, int'(q),          int'(cur.q));
      chk("bit_cnt",    cur.idx, int'(bit_cnt),    int'(cur.cnt));
      chk("word_valid", cur.idx, int'(word_valid), int'(cur.wv));
      chk("sdo_r",      cur.idx, int'(sdo_r),      int'(cur.q[0]));
      chk("sdo_l",      cur.idx, int'(sdo_l),      int'(cur.q[7]));
    end
  end

  task automatic step(input logic rs, input logic cl, input logic e, input logic [1:0] m,
                      input logic sl, input logic sr, input logic [7:0] p,
                      input logic [7:0] eq, input logic [3:0] ec, input logic ew);
    exp_t x;
    @(negedge clk);
    reset = rs; clr = cl; en = e; mode = m; sdi_l = sl; sdi_r = sr; pdi = p;
    step_no++;
    x.idx = step_no; x.q = eq; x.cnt = ec; x.wv = ew;
    sb.push_back(x);
  endtask

  task automatic shl(input logic sr, input logic [7:0] eq, input logic [3:0] ec, input logic ew);
    step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, sr, 8'h00, eq, ec, ew);
  endtask

  task automatic shr(input logic sl, input logic [7:0] eq, input logic [3:0] ec, input logic ew);
    step(1'b0, 1'b0, 1'b1, 2'b01, sl, 1'b0, 8'h00, eq, ec, ew);
  endtask

  initial begin
    // Reset held 2 edges while a load of 0xFF is requested.
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 8'h00, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 8'h00, 4'd0, 1'b0);

    // Shift left 1,0,1,0,0,1,0,1 -> 0xA5 with one word_valid pulse.
    shl(1'b1, 8'h01, 4'd1, 1'b0);
    shl(1'b0, 8'h02, 4'd2, 1'b0);
    shl(1'b1, 8'h05, 4'd3, 1'b0);
    shl(1'b0, 8'h0A, 4'd4, 1'b0);
    shl(1'b0, 8'h14, 4'd5, 1'b0);
    shl(1'b1, 8'h29, 4'd6, 1'b0);
    shl(1'b0, 8'h52, 4'd7, 1'b0);
    shl(1'b1, 8'hA5, 4'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 8'h00, 8'hA5, 4'd0, 1'b0);

    // Shift right 1,0,1,0,(3 idle),0,1,0,1 starting from 0xA5.
    shr(1'b1, 8'hD2, 4'd1, 1'b0);
    shr(1'b0, 8'h69, 4'd2, 1'b0);
    shr(1'b1, 8'hB4, 4'd3, 1'b0);
    shr(1'b0, 8'h5A, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 8'h5A, 4'd4, 1'b0);
    shr(1'b0, 8'h2D, 4'd5, 1'b0);
    shr(1'b1, 8'h96, 4'd6, 1'b0);
    shr(1'b0, 8'h4B, 4'd7, 1'b0);
    shr(1'b1, 8'hA5, 4'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, 8'hA5, 4'd0, 1'b0);

    // PISO: load 0x3C, then 8 right shifts of zero; sdo_r reads 0,0,1,1,1,1,0,0.
    step(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, 8'h3C, 4'd0, 1'b0);
    shr(1'b0, 8'h1E, 4'd1, 1'b0);
    shr(1'b0, 8'h0F, 4'd2, 1'b0);
    shr(1'b0, 8'h07, 4'd3, 1'b0);
    shr(1'b0, 8'h03, 4'd4, 1'b0);
    shr(1'b0, 8'h01, 4'd5, 1'b0);
    shr(1'b0, 8'h00, 4'd6, 1'b0);
    shr(1'b0, 8'h00, 4'd7, 1'b0);
    shr(1'b0, 8'h00, 4'd0, 1'b1);

    // clr after 5 shifts: q kept, a full 8 further shifts needed for the next word.
    shl(1'b1, 8'h01, 4'd1, 1'b0);
    shl(1'b1, 8'h03, 4'd2, 1'b0);
    shl(1'b1, 8'h07, 4'd3, 1'b0);
    shl(1'b1, 8'h0F, 4'd4, 1'b0);
    shl(1'b1, 8'h1F, 4'd5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 8'h1F, 4'd0, 1'b0);
    shl(1'b0, 8'h3E, 4'd1, 1'b0);
    shl(1'b0, 8'h7C, 4'd2, 1'b0);
    shl(1'b0, 8'hF8, 4'd3, 1'b0);
    shl(1'b0, 8'hF0, 4'd4, 1'b0);
    shl(1'b0, 8'hE0, 4'd5, 1'b0);
    shl(1'b0, 8'hC0, 4'd6, 1'b0);
    shl(1'b0, 8'h80, 4'd7, 1'b0);
    shl(1'b0, 8'h00, 4'd0, 1'b1);

    // Reset after 3 shifts, together with a load of 0x55.
    shl(1'b1, 8'h01, 4'd1, 1'b0);
    shl(1'b1, 8'h03, 4'd2, 1'b0);
    shl(1'b1, 8'h07, 4'd3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h55, 8'h00, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h55, 8'h00, 4'd0, 1'b0);

    // Direction change keeps counting; a load mid-word discards the count.
    shr(1'b1, 8'h80, 4'd1, 1'b0);
    shl(1'b1, 8'h01, 4'd2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hC3, 8'hC3, 4'd0, 1'b0);
    shl(1'b0, 8'h86, 4'd1, 1'b0);

    @(negedge clk);
    en = 1'b0; mode = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
Parametrised universal shift register with word framing. It is the generalised successor to the 4-bit serial-in/parallel-out register and supports hold, shift right, shift left and parallel load. A bit counter tracks serial bits. A one-cycle word_valid strobe fires each time WIDTH bits have been shifted in. It sits between serial links (SPI-like, bit-bang) and word-wide datapaths, and works as SIPO, PISO or bidirectional shifter.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.
CW (localparam), $clog2(WIDTH+1), bit counter width; equals 4 for WIDTH=8.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  synchronous, active-high reset.
clr  input  1  synchronous clear of the bit counter only; q is kept.
en  input  1  operation enable; when 0, the register holds.
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
sdi_l  input  1  serial bit entering at the MSB on shift right.
sdi_r  input  1  serial bit entering at the LSB on shift left.
pdi  input  WIDTH  parallel load data.
q  output  WIDTH  register contents (registered).
sdo_r  output  1  equals q[0]; combinational from q.
sdo_l  output  1  equals q[WIDTH-1]; combinational from q.
bit_cnt  output  CW  bits shifted in the current word, 0..WIDTH-1 (registered).
word_valid  output  1  one-cycle strobe: q holds a complete shifted word (registered).

Behaviour:
- All state updates on the rising edge of clk. Priority per edge: reset > clr > en/mode.
- reset=1: q=0, bit_cnt=0, word_valid=0. This applies regardless of clr, en, mode and mid-word state.
- clr=1 (reset=0): bit_cnt=0 and word_valid=0. q is unchanged and no shift occurs that cycle.
- en=0 or mode=00: q and bit_cnt hold; word_valid=0.
- mode=01 (shift right): q <= {sdi_l, q[WIDTH-1:1]}.
- mode=10 (shift left): q <= {q[WIDTH-2:0], sdi_r}.
- Counting on a shift:
  - If bit_cnt == WIDTH-1: bit_cnt wraps to 0 and word_valid=1 on the next cycle.
  - Otherwise: bit_cnt+1 and word_valid=0.
- word_valid timing: it is high in the same cycle q first shows the completed word. Back-to-back words give an isolated 1-cycle pulse every WIDTH shifting cycles.
- mode=11 (parallel load): q <= pdi, bit_cnt=0, word_valid=0. A load mid-word discards the partial count.
- Direction change mid-word: bit_cnt keeps counting regardless of direction. Framing is per shift, not per direction.
- Idle cycles (en=0 or hold) between shifts do not disturb bit_cnt. A word may be spread over any number of cycles.
- Latency: q, bit_cnt and word_valid are visible one cycle after the controlling edge. sdo_l and sdo_r follow q with zero added latency.
- No X propagation:
  - Undriven mode is not a legal operating condition.
  - After reset, every output is defined.

Test Plan:
- Reset: hold reset=1 for 2 edges with en=1, mode=11, pdi=0xFF -> q=0x00, bit_cnt=0, word_valid=0.
- Shift left, WIDTH=8: release reset; mode=10, en=1; drive sdi_r=1,0,1,0,0,1,0,1 on 8 consecutive edges -> q=0xA5, bit_cnt=0, word_valid=1 for exactly 1 cycle after the 8th edge, then 0.
- Shift right: mode=01, sdi_l=1,0,1,0,0,1,0,1 -> q=0xA5. Insert 3 en=0 cycles after bit 4 -> bit_cnt holds at 4 and word_valid still pulses only after the 8th shift.
- PISO: load pdi=0x3C (mode=11); then 8 shift-right edges with sdi_l=0 -> sdo_r sequence 0,0,1,1,1,1,0,0, final q=0x00, one word_valid pulse.
- clr mid-word: after 5 shifts assert clr=1 for 1 edge -> bit_cnt=0, q unchanged. The next word_valid requires 8 further shifts.
- Reset mid-word: after 3 shifts assert reset together with mode=11, pdi=0x55 -> q=0x00, bit_cnt=0, no word_valid.
